// File: rtl/bcm_update_scheduler_pkg.sv
// Shared types and helpers for the time-multiplexed BCM plasticity scheduler.
// Values are signed Q2.16; per-synapse state is {w, r1, r2, o1}.
package bcm_pkg;

  localparam int BCM_W = 18;

  typedef logic signed [BCM_W-1:0] q2_16_t;

  localparam q2_16_t BCM_ONE = 18'sh1_0000;

  typedef struct packed {
    q2_16_t w;
    q2_16_t r1;
    q2_16_t r2;
    q2_16_t o1;
  } bcm_syn_t;

  localparam bcm_syn_t BCM_SYN_RST = '{w: 18'sh0_0000, r1: BCM_ONE, r2: BCM_ONE, o1: BCM_ONE};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } bcm_state_e;

  // Trace update: reload to 1.0 on a spike, otherwise exponential decay by 2^-sh.
  function automatic q2_16_t bcm_decay(input q2_16_t v, input int unsigned sh, input logic load_one);
    q2_16_t r;
    if (load_one) begin
      r = BCM_ONE;
    end else begin
      r = v - (v >>> sh);
    end
    return r;
  endfunction

endpackage

// File: rtl/bcm_update_scheduler_if.sv
// Host-side bus of the BCM update scheduler: tick/spike capture, weight
// preload, combinational weight readback and sweep status.
interface bcm_update_scheduler_if
  import bcm_pkg::*;
#(
  parameter int N_SYN = 8
) ();

  localparam int IDX_W = $clog2(N_SYN);

  logic             tick;
  logic [N_SYN-1:0] pre_spk;
  logic [N_SYN-1:0] post_spk;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  q2_16_t           wr_w;
  logic [IDX_W-1:0] rd_idx;
  q2_16_t           rd_w;
  logic             busy;
  logic             done;
  logic             overrun;

  modport master (
    output tick, pre_spk, post_spk, wr_en, wr_idx, wr_w, rd_idx,
    input  rd_w, busy, done, overrun
  );

  modport slave (
    input  tick, pre_spk, post_spk, wr_en, wr_idx, wr_w, rd_idx,
    output rd_w, busy, done, overrun
  );

endinterface

// File: rtl/bcm_update_scheduler_engine.sv
// Shared BCM engine: trace decay plus weight update, ENG_LAT register stages.
// Weight clamping to [W_MIN, W_MAX] is enabled by defining BCM_SAT_EN.
module bcm_update_engine
  import bcm_pkg::*;
#(
  parameter int     T_PLUS   = 4,
  parameter int     T_MINUS  = 5,
  parameter int     T_Y      = 5,
  parameter int     A3_PLUS  = 4,
  parameter int     A2_MINUS = 7,
  parameter int     ENG_LAT  = 3,
  parameter q2_16_t W_MAX    = 18'sh1_0000,
  parameter q2_16_t W_MIN    = -18'sh1_0000
) (
  input  logic     clk,
  input  logic     rst,
  input  bcm_syn_t syn_i,
  input  logic     pre_i,
  input  logic     post_i,
  output bcm_syn_t syn_o
);

  logic signed [2*BCM_W-1:0] prod_s;
  q2_16_t                    p_s;
  q2_16_t                    pot_s;
  q2_16_t                    dep_s;
  logic signed [BCM_W:0]     sum_s;
  q2_16_t                    w_next_s;
  bcm_syn_t                  res_s;
  bcm_syn_t                  pipe_q [ENG_LAT];

  // Combinational update, all terms from the pre-update state.
  always_comb begin
    prod_s = (2*BCM_W)'(syn_i.r2) * (2*BCM_W)'(syn_i.o1);
    p_s    = q2_16_t'(prod_s >>> 16);
    pot_s  = post_i ? (p_s >>> A3_PLUS) : 18'sh0_0000;
    dep_s  = pre_i ? (syn_i.r1 >>> A2_MINUS) : 18'sh0_0000;
    sum_s  = (BCM_W+1)'(syn_i.w) + (BCM_W+1)'(pot_s) - (BCM_W+1)'(dep_s);
`ifdef BCM_SAT_EN
    if (sum_s > (BCM_W+1)'(W_MAX)) begin
      w_next_s = W_MAX;
    end else if (sum_s < (BCM_W+1)'(W_MIN)) begin
      w_next_s = W_MIN;
    end else begin
      w_next_s = q2_16_t'(sum_s);
    end
`else
    w_next_s = q2_16_t'(sum_s);
`endif
    res_s.w  = w_next_s;
    res_s.r1 = bcm_decay(syn_i.r1, T_MINUS, post_i);
    res_s.r2 = bcm_decay(syn_i.r2, T_PLUS, pre_i);
    res_s.o1 = bcm_decay(syn_i.o1, T_Y, post_i);
  end

  // Latency pipeline; free-running, the scheduler decides when to consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENG_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= res_s;
      for (int i = 1; i < ENG_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign syn_o = pipe_q[ENG_LAT-1];

endmodule

// File: rtl/bcm_update_scheduler.sv
// Sweeps N_SYN synapses through one shared BCM engine per timestep tick.
// Optional weight saturation: define BCM_SAT_EN.
module bcm_update_scheduler
  import bcm_pkg::*;
#(
  parameter int     N_SYN    = 8,
  parameter int     T_PLUS   = 4,
  parameter int     T_MINUS  = 5,
  parameter int     T_Y      = 5,
  parameter int     A3_PLUS  = 4,
  parameter int     A2_MINUS = 7,
  parameter int     ENG_LAT  = 3,
  parameter q2_16_t W_MAX    = 18'sh1_0000,
  parameter q2_16_t W_MIN    = -18'sh1_0000
) (
  input logic                   clk,
  input logic                   rst,
  bcm_update_scheduler_if.slave sched
);

  localparam int IDX_W = $clog2(N_SYN);
  localparam int WC_W  = $clog2(ENG_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SYN - 1);
  localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(ENG_LAT - 1);

  bcm_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [N_SYN-1:0] pre_q, pre_d;
  logic [N_SYN-1:0] post_q, post_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             last_s;
  logic             wb_en_s;
  logic             pl_en_s;
  bcm_syn_t         eng_out_s;
  bcm_syn_t         sf_q [N_SYN];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; WAIT spans ENG_LAT cycles, so each synapse takes ENG_LAT+2.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = sched.tick ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = (wcnt_q == WAIT_LAST) ? ST_WRITE : ST_WAIT;
      ST_WRITE: state_d = last_s ? ST_IDLE : ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath controls and next values of the status registers.
  always_comb begin
    last_s  = (idx_q == LAST_IDX);
    wb_en_s = (state_q == ST_WRITE);
    pl_en_s = sched.wr_en && !busy_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    pre_d   = pre_q;
    post_d  = post_q;
    ovr_d   = ovr_q;
    case (state_q)
      ST_IDLE: begin
        if (sched.tick) begin
          idx_d  = '0;
          pre_d  = sched.pre_spk;
          post_d = sched.post_spk;
        end else begin
          idx_d = idx_q;
        end
      end
      ST_ISSUE: wcnt_d = '0;
      ST_WAIT:  wcnt_d = wcnt_q + WC_W'(1);
      ST_WRITE: idx_d  = last_s ? idx_q : idx_q + IDX_W'(1);
      default:  idx_d  = idx_q;
    endcase
    if (sched.tick && (state_q != ST_IDLE)) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_q;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = wb_en_s && last_s;
  end

  // Index, wait counter, spike latches and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      wcnt_q <= '0;
      pre_q  <= '0;
      post_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      wcnt_q <= wcnt_d;
      pre_q  <= pre_d;
      post_q <= post_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovr_q  <= ovr_d;
    end
  end

  // State file: engine write-back while sweeping, host preload only when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SYN; i++) begin
        sf_q[i] <= BCM_SYN_RST;
      end
    end else if (wb_en_s) begin
      sf_q[idx_q] <= eng_out_s;
    end else if (pl_en_s) begin
      sf_q[sched.wr_idx].w <= sched.wr_w;
    end
  end

  bcm_update_engine #(
    .T_PLUS   (T_PLUS),
    .T_MINUS  (T_MINUS),
    .T_Y      (T_Y),
    .A3_PLUS  (A3_PLUS),
    .A2_MINUS (A2_MINUS),
    .ENG_LAT  (ENG_LAT),
    .W_MAX    (W_MAX),
    .W_MIN    (W_MIN)
  ) u_engine (
    .clk    (clk),
    .rst    (rst),
    .syn_i  (sf_q[idx_q]),
    .pre_i  (pre_q[idx_q]),
    .post_i (post_q[idx_q]),
    .syn_o  (eng_out_s)
  );

  assign sched.rd_w    = sf_q[sched.rd_idx].w;
  assign sched.busy    = busy_q;
  assign sched.done    = done_q;
  assign sched.overrun = ovr_q;

endmodule

// File: tb/tb_bcm_update_scheduler.sv
// Bench for bcm_update_scheduler (N_SYN=4): integer-arithmetic sweep model
// checked every cycle, plus directed scenarios with hand-computed values.
module tb_bcm_update_scheduler;
  import bcm_pkg::*;

  localparam int N  = 4;
  localparam int L  = 3;
  localparam int P  = L + 2;
  localparam int T  = N * P;
  localparam int IW = $clog2(N);
  localparam int TP = 4, TM = 5, TY = 5, A3 = 4, A2 = 7;
  localparam int ONE = 65536;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcm_update_scheduler_if #(.N_SYN(N)) bus ();

  bcm_update_scheduler #(.N_SYN(N), .ENG_LAT(L)) dut (
    .clk   (clk),
    .rst   (rst),
    .sched (bus)
  );

  typedef struct {
    int w;
    int r1;
    int r2;
    int o1;
  } msyn_t;

  msyn_t m_vis [N];
  msyn_t m_res [N];
  int    m_cnt  = 0;
  bit    m_done = 1'b0;
  bit    m_ovr  = 1'b0;
  bit    chk_en = 1'b0;
  int    n_pass = 0;
  int    n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  function automatic int wrap18(input longint x);
    longint y;
    y = x & 64'h3FFFF;
    return (y >= 64'd131072) ? int'(y - 64'd262144) : int'(y);
  endfunction

  function automatic msyn_t step(input msyn_t s, input bit pre, input bit post, input int w_in);
    msyn_t n;
    int p, dw;
    longint sum;
    n.r1 = post ? ONE : s.r1 - (s.r1 >>> TM);
    n.r2 = pre  ? ONE : s.r2 - (s.r2 >>> TP);
    n.o1 = post ? ONE : s.o1 - (s.o1 >>> TY);
    p    = wrap18((longint'(s.r2) * longint'(s.o1)) >>> 16);
    dw   = (post ? (p >>> A3) : 0) - (pre ? (s.r1 >>> A2) : 0);
    sum  = longint'(w_in) + longint'(dw);
`ifdef BCM_SAT_EN
    if (sum > 64'sd65536) n.w = ONE;
    else if (sum < -64'sd65536) n.w = -ONE;
    else n.w = int'(sum);
`else
    n.w = wrap18(sum);
`endif
    return n;
  endfunction

  // Timeline model: a sweep is T busy cycles, synapse k becomes visible after edge (k+1)*P.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_ovr  <= 1'b0;
      for (int i = 0; i < N; i++) m_vis[i] <= '{w: 0, r1: ONE, r2: ONE, o1: ONE};
    end else begin
      m_done <= (m_cnt == T);
      if (m_cnt == 0) begin
        if (bus.wr_en) m_vis[bus.wr_idx].w <= int'(bus.wr_w);
        if (bus.tick) begin
          for (int i = 0; i < N; i++)
            m_res[i] <= step(m_vis[i], bus.pre_spk[i], bus.post_spk[i],
                             (bus.wr_en && int'(bus.wr_idx) == i) ? int'(bus.wr_w) : m_vis[i].w);
          m_cnt <= 1;
        end
      end else begin
        if (bus.tick) m_ovr <= 1'b1;
        if (m_cnt % P == 0) m_vis[m_cnt / P - 1] <= m_res[m_cnt / P - 1];
        m_cnt <= (m_cnt == T) ? 0 : m_cnt + 1;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", longint'(bus.busy), longint'(m_cnt != 0));
      check("done", longint'(bus.done), longint'(m_done));
      check("overrun", longint'(bus.overrun), longint'(m_ovr));
      check("rd_w", longint'(int'(bus.rd_w)), longint'(m_vis[bus.rd_idx].w));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.wr_en = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic tick_once(input logic [N-1:0] pre, input logic [N-1:0] post);
    bus.tick = 1'b1;
    bus.pre_spk = pre;
    bus.post_spk = post;
    cyc(1);
    bus.tick = 1'b0;
    bus.pre_spk = N'($urandom);
    bus.post_spk = N'($urandom);
  endtask

  task automatic wait_done(input int budget, output int busy_n, output int done_at);
    busy_n = 0;
    done_at = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_at = c;
        break;
      end
    end
    if (done_at == 0) check("sweep_timeout", 0, 1);
  endtask

  task automatic rd_check(input string name, input int idx, input logic [17:0] exp);
    @(negedge clk);
    #2;
    bus.rd_idx = IW'(idx);
    #1;
    check(name, longint'($unsigned(bus.rd_w)), longint'(exp));
  endtask

  task automatic check_state;
    for (int i = 0; i < N; i++) begin
      check("sf_w", longint'(int'(dut.sf_q[i].w)), longint'(m_vis[i].w));
      check("sf_r1", longint'(int'(dut.sf_q[i].r1)), longint'(m_vis[i].r1));
      check("sf_r2", longint'(int'(dut.sf_q[i].r2)), longint'(m_vis[i].r2));
      check("sf_o1", longint'(int'(dut.sf_q[i].o1)), longint'(m_vis[i].o1));
    end
  endtask

  int bn, da, dn;

  initial begin
    bus.tick = 1'b0; bus.pre_spk = '0; bus.post_spk = '0;
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_w = '0; bus.rd_idx = '0;
    do_reset();
    chk_en = 1'b1;

    // Reset state
    check("reset_busy", longint'(bus.busy), 0);
    check_state();
    for (int i = 0; i < N; i++) check("reset_r1", longint'($unsigned(dut.sf_q[i].r1)), 18'h10000);

    // Single post spike on synapse 0
    tick_once(4'b0000, 4'b0001);
    wait_done(200, bn, da);
    check("t1_busy_len", bn, 20);
    check("t1_done_cycle", da, 21);
    check_state();
    check("t1_model_w0", m_vis[0].w, 4096);
    for (int i = 1; i < N; i++) begin
      check("t1_r1", longint'($unsigned(dut.sf_q[i].r1)), 18'h0F800);
      check("t1_o1", longint'($unsigned(dut.sf_q[i].o1)), 18'h0F800);
      check("t1_r2", longint'($unsigned(dut.sf_q[i].r2)), 18'h0F000);
    end
    rd_check("t1_w0", 0, 18'h01000);

    // Single pre spike on synapse 1
    do_reset();
    tick_once(4'b0010, 4'b0000);
    wait_done(200, bn, da);
    check_state();
    check("t2_model_w1", m_vis[1].w, -512);
    check("t2_r2_1", longint'($unsigned(dut.sf_q[1].r2)), 18'h10000);
    rd_check("t2_w1", 1, 18'h3FE00);
    rd_check("t2_w0", 0, 18'h00000);
    rd_check("t2_w2", 2, 18'h00000);
    rd_check("t2_w3", 3, 18'h00000);

    // Back-to-back: tick in the done cycle is accepted
    tick_once(4'b0000, 4'b1000);
    wait_done(200, bn, da);
    bus.tick = 1'b1;
    bus.pre_spk = 4'b0001;
    bus.post_spk = 4'b0100;
    cyc(1);
    bus.tick = 1'b0;
    wait_done(200, bn, da);
    check("t2b_busy_len", bn, 20);
    check("t2b_no_overrun", longint'(bus.overrun), 0);
    check_state();

    // Saturation on synapse 2
    do_reset();
    bus.wr_en = 1'b1; bus.wr_idx = 2'd2; bus.wr_w = 18'sh0_FF00;
    cyc(1);
    bus.wr_en = 1'b0;
    tick_once(4'b0000, 4'b0100);
    wait_done(200, bn, da);
    check_state();
`ifdef BCM_SAT_EN
    rd_check("t3_w2_sat", 2, 18'h10000);
`else
    rd_check("t3_w2_wrap", 2, 18'h10F00);
`endif

    // Overrun: second tick 5 cycles into the sweep is dropped
    do_reset();
    tick_once(4'b0000, 4'b1111);
    cyc(4);
    tick_once(4'b1111, 4'b0000);
    dn = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("t4_done_pulses", dn, 1);
    check("t4_overrun", longint'(bus.overrun), 1);
    check_state();
    for (int i = 0; i < N; i++) rd_check("t4_w", i, 18'h01000);
    cyc(5);
    check("t4_overrun_sticky", longint'(bus.overrun), 1);

    // Reset at cycle 8 of a sweep
    tick_once(4'b0000, 4'b0011);
    cyc(7);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t5_busy", longint'(bus.busy), 0);
    check("t5_overrun", longint'(bus.overrun), 0);
    for (int i = 0; i < N; i++) begin
      check("t5_w", longint'($unsigned(dut.sf_q[i].w)), 18'h00000);
      check("t5_r1", longint'($unsigned(dut.sf_q[i].r1)), 18'h10000);
      check("t5_r2", longint'($unsigned(dut.sf_q[i].r2)), 18'h10000);
      check("t5_o1", longint'($unsigned(dut.sf_q[i].o1)), 18'h10000);
    end

    // Preload while busy is ignored
    tick_once(4'b0000, 4'b0000);
    cyc(3);
    bus.wr_en = 1'b1; bus.wr_idx = 2'd3; bus.wr_w = 18'sh0_0500;
    cyc(1);
    bus.wr_en = 1'b0;
    wait_done(200, bn, da);
    rd_check("t6_w3_ignored", 3, 18'h00000);

    // Preload together with tick in IDLE
    do_reset();
    bus.wr_en = 1'b1; bus.wr_idx = 2'd3; bus.wr_w = 18'sh0_0500;
    tick_once(4'b0000, 4'b1000);
    bus.wr_en = 1'b0;
    wait_done(200, bn, da);
    check_state();
    rd_check("t6_w3", 3, 18'h01500);

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
